// File: rtl/cnn_pkg.sv
// Shared CNN constants and small arithmetic helpers.
//   conv2 geometry : CONV2_DATA_W-bit signed results, CONV2_MAP_W x CONV2_MAP_H per channel
//   pool2 geometry : POOL2_MAP_W x POOL2_MAP_H after 2x2 stride-2 max pooling
//   relu()         : clamps a signed conv2 result to >= 0
//   max2()         : unsigned maximum of two non-negative values
package cnn_pkg;

  localparam int CONV2_DATA_W = 14;
  localparam int CONV2_MAP_W  = 8;
  localparam int CONV2_MAP_H  = 8;
  localparam int POOL2_MAP_W  = 4;
  localparam int POOL2_MAP_H  = 4;

  typedef logic signed [CONV2_DATA_W-1:0] conv2_s_t;
  typedef logic        [CONV2_DATA_W-1:0] conv2_u_t;

  // Negative inputs become zero; zero and positive values pass unchanged.
  function automatic conv2_u_t relu(input conv2_s_t x);
    return x[CONV2_DATA_W-1] ? '0 : conv2_u_t'(x);
  endfunction

  // Operands are ReLU outputs, so an unsigned compare orders them correctly.
  function automatic conv2_u_t max2(input conv2_u_t a, input conv2_u_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Register line buffer holding one horizontal-pair maximum per pooling window
// of the current window row.
//   clk     : rising-edge clock
//   wr_en   : write wr_data into entry wr_idx this edge
//   wr_idx  : write entry index
//   wr_data : value to store
//   rd_idx  : read entry index
//   rd_data : combinational read of entry rd_idx
// Contents are not reset: every entry is written on an even row before the
// following odd row reads it.
module pool_line_buf #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/conv2_relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over one streamed conv2 feature map.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   in_valid   : conv_in carries one pixel this cycle (gaps allowed)
//   conv_in    : signed conv2 result, row-major
//   out_valid  : one-cycle pulse per pooled result, one cycle after the
//                accepting edge of the window's last pixel
//   pool_out   : pooled value (never negative); holds between pulses
//   frame_done : pulses with the last pooled output of a frame
// Handshake: in_valid is a pure qualifier with no ready; out_valid is a pure
// pulse with no backpressure, so the consumer must take every pulse.
// DATA_W is expected to match CONV2_DATA_W, the width of the package helpers.
module conv2_relu_maxpool
  import cnn_pkg::*;
#(
  parameter int DATA_W = CONV2_DATA_W,
  parameter int IMG_W  = CONV2_MAP_W,
  parameter int IMG_H  = CONV2_MAP_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] conv_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] pool_out,
  output logic              frame_done
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_D  = IMG_W / 2;
  localparam int LB_IW = (LB_D > 1) ? $clog2(LB_D) : 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] pair_reg;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] pm;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] pooled;
  logic [LB_IW-1:0]  lb_idx;
  logic              lb_wr;
  logic              col_last;
  logic              row_last;

  always_comb begin
    r        = DATA_W'(relu(conv2_s_t'(conv_in)));
    // Horizontal max of the current pair; meaningful on odd columns only.
    pm       = DATA_W'(max2(conv2_u_t'(pair_reg), conv2_u_t'(r)));
    // Vertical max against the pair stored from the even row above.
    pooled   = DATA_W'(max2(conv2_u_t'(lb_rd), conv2_u_t'(pm)));
    lb_idx   = LB_IW'(col >> 1);
    col_last = (col == CW'(IMG_W - 1));
    row_last = (row == RW'(IMG_H - 1));
    lb_wr    = in_valid && !row[0] && col[0];
  end

  // Even rows write and odd rows read, so a given entry never sees a read and
  // a write in the same cycle; sharing one index for both ports is safe.
  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (LB_D),
    .IDX_W  (LB_IW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_wr),
    .wr_idx  (lb_idx),
    .wr_data (pm),
    .rd_idx  (lb_idx),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      pair_reg   <= '0;
      out_valid  <= 1'b0;
      pool_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (!col[0]) pair_reg <= r;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (row[0] && col[0]) begin
          pool_out   <= pooled;
          out_valid  <= 1'b1;
          frame_done <= row_last && col_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2_relu_maxpool.sv
// Directed bench for conv2_relu_maxpool: the stimulus driver pushes
// hand-derived pooled values into a scoreboard queue; an independent monitor
// pops and compares on every out_valid pulse.
module tb_conv2_relu_maxpool;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] conv_in;
  logic         out_valid;
  logic [W-1:0] pool_out;
  logic         frame_done;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  conv2_relu_maxpool dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .conv_in    (conv_in),
    .out_valid  (out_valid),
    .pool_out   (pool_out),
    .frame_done (frame_done)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_fd_q[$];
  int           checks = 0;
  int           errors = 0;
  int           fd_cnt = 0;
  logic         oo_flag;   // driven pixel is at an odd row and odd column
  logic         last_oo;   // an odd/odd pixel was accepted at the last edge

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) last_oo <= 1'b0;
    else     last_oo <= in_valid && oo_flag;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic         efd;
    if (!rst) begin
      if (out_valid || last_oo) chk("pulse_timing", 32'(out_valid), 32'(last_oo));
      if (frame_done) chk("frame_done_qualified", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (frame_done) fd_cnt++;
        chk("pool_out_msb", 32'(pool_out[W-1]), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d, expected no output", pool_out);
        end else begin
          e   = exp_q.pop_front();
          efd = exp_fd_q.pop_front();
          chk("pool_out", 32'(pool_out), 32'(e));
          chk("frame_done", 32'(frame_done), 32'(efd));
        end
      end
    end
  end

  // ---------------- stimulus tables ----------------
  // mode 0: ramp r*8+c; 1: all -100; 2: single 8191 per chosen window, else -5;
  // mode 3: negated ramp
  function automatic logic [W-1:0] pix(input int mode, input int r, input int c);
    case (mode)
      0:       return W'(r * 8 + c);
      1:       return W'(-100);
      2:       return ((r == 0 && c == 0) || (r == 1 && c == 3) ||
                       (r == 4 && c == 5) || (r == 7 && c == 6)) ? W'(8191) : W'(-5);
      default: return W'(-(r * 8 + c));
    endcase
  endfunction

  // Hand-derived pooled results: for the ramp each window's max is its
  // bottom-right pixel, (2*pr+1)*8 + 2*pc+1 = 9,11,13,15,25,...,63.
  function automatic logic [W-1:0] exp_val(input int mode, input int idx);
    int pr, pc;
    pr = idx / 4;
    pc = idx % 4;
    case (mode)
      0:       return W'((2 * pr + 1) * 8 + 2 * pc + 1);
      2:       return (idx == 0 || idx == 1 || idx == 10 || idx == 15) ? W'(8191) : W'(0);
      default: return W'(0);
    endcase
  endfunction

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic push_exp(input int mode, input int n_out, input bit full);
    for (int i = 0; i < n_out; i++) begin
      exp_q.push_back(exp_val(mode, i));
      exp_fd_q.push_back(full && (i == 15));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      oo_flag  = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send(input int mode, input int npix, input bit gaps);
    int r, c;
    for (int i = 0; i < npix; i++) begin
      r = i / 8;
      c = i % 8;
      if (gaps) idle(int'($urandom_range(0, 1)));
      in_valid = 1'b1;
      conv_in  = pix(mode, r, c);
      oo_flag  = (r % 2 == 1) && (c % 2 == 1);
      @(negedge clk);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    conv_in  = '0;
    oo_flag  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_pool_out", 32'(pool_out), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Contiguous ramp, then pool_out must hold the last value.
    push_exp(0, 16, 1'b1);
    send(0, 64, 1'b0);
    idle(4);
    chk("pool_out_hold", 32'(pool_out), 32'd63);

    // All-negative frame.
    push_exp(1, 16, 1'b1);
    send(1, 64, 1'b0);
    idle(3);

    // One positive pixel in four windows.
    push_exp(2, 16, 1'b1);
    send(2, 64, 1'b0);
    idle(3);

    // Ramp with random idle gaps.
    push_exp(0, 16, 1'b1);
    send(0, 64, 1'b1);
    idle(3);

    // Back-to-back ramp and negated ramp with no bubble.
    push_exp(0, 16, 1'b1);
    send(0, 64, 1'b0);
    push_exp(3, 16, 1'b1);
    send(3, 64, 1'b0);
    idle(3);

    // Reset after 37 pixels: the pooled rows already completed (8 results)
    // have been emitted; nothing more may come from the aborted frame.
    push_exp(0, 8, 1'b0);
    send(0, 37, 1'b0);
    in_valid = 1'b0;
    oo_flag  = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_pool_out", 32'(pool_out), 32'd0);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    idle(2);
    push_exp(0, 16, 1'b1);
    send(0, 64, 1'b0);
    idle(5);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_done_count", 32'(fd_cnt), 32'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end

endmodule
